// File: rtl/multicycle_control_pkg.sv
// Shared opcode, state and select encodings for the multi-cycle MIPS controller.
// The control vector struct is the contract between the FSM top and its output decoder.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_OP_ADD   = 3'b000;
    localparam logic [2:0] ALU_OP_SUB   = 3'b001;
    localparam logic [2:0] ALU_OP_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OP_AND   = 3'b011;
    localparam logic [2:0] ALU_OP_OR    = 3'b100;
    localparam logic [2:0] ALU_OP_SLT   = 3'b101;

    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_IMM_EX   = 4'd10,
        S_IMMWB    = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_beq;
        logic       pc_write_bne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       ext_sign;
    } ctrl_t;

    // andi/ori treat the immediate as an unsigned bit mask
    function automatic logic imm_is_signed(input logic [5:0] op);
        return !(op == OP_ANDI || op == OP_ORI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: IR opcode and memory handshake in, selects/enables out.
// master = controller side, slave = datapath side.
interface multicycle_control_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_beq;
    logic             pc_write_bne;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic [1:0]       pc_source;
    logic             ext_sign;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       state_dbg;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, ext_sign, illegal_op, instr_count, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, pc_source, ext_sign, illegal_op, instr_count, state_dbg
    );
endinterface

// File: rtl/multicycle_control_outdec.sv
// Combinational Moore decode of {state, latched opcode} into the datapath control vector.
// Only FETCH looks at mem_ready, to gate the IR and PC loads.
module multicycle_control_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op_q,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);
    always_comb begin
        ctrl          = '0;
        ctrl.ext_sign = 1'b1;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUSRCB_FOUR;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = ALUSRCB_IMM_SH;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_RTYPE_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_B;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a    = 1'b1;
                ctrl.alu_src_b    = ALUSRCB_B;
                ctrl.alu_op       = ALU_OP_SUB;
                ctrl.pc_source    = PCSRC_ALUOUT;
                ctrl.pc_write_beq = (op_q == OP_BEQ);
                ctrl.pc_write_bne = (op_q == OP_BNE);
            end
            S_IMM_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
                ctrl.ext_sign  = imm_is_signed(op_q);
                case (op_q)
                    OP_SLTI: ctrl.alu_op = ALU_OP_SLT;
                    OP_ANDI: ctrl.alu_op = ALU_OP_AND;
                    OP_ORI:  ctrl.alu_op = ALU_OP_OR;
                    default: ctrl.alu_op = ALU_OP_ADD;
                endcase
            end
            S_IMMWB: begin
                // extender mode held so the immediate seen by writeback stays consistent
                ctrl.reg_write = 1'b1;
                ctrl.ext_sign  = imm_is_signed(op_q);
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: state register, opcode latch, next-state and retire counter.
// Output selects come from multicycle_control_outdec; illegal_op is flagged from the live opcode in DECODE.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  bus
);
    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal;
    ctrl_t            ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        illegal = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = bus.opcode;
                case (bus.opcode)
                    OP_LW, OP_SW:                       state_d = S_MEMADR;
                    OP_RTYPE:                           state_d = S_RTYPE_EX;
                    OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  state_d = S_IMM_EX;
                    OP_J:                               state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (bus.mem_ready) state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_IMM_EX:   state_d = S_IMMWB;
            S_IMMWB:    state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Every return to FETCH retires one instruction (illegal ones included); leaving IDLE does not.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_IDLE)
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    multicycle_control_outdec u_outdec (
        .state     (state_q),
        .op_q      (op_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.pc_write     = ctrl.pc_write;
    assign bus.pc_write_beq = ctrl.pc_write_beq;
    assign bus.pc_write_bne = ctrl.pc_write_bne;
    assign bus.i_or_d       = ctrl.i_or_d;
    assign bus.mem_read     = ctrl.mem_read;
    assign bus.mem_write    = ctrl.mem_write;
    assign bus.ir_write     = ctrl.ir_write;
    assign bus.reg_dst      = ctrl.reg_dst;
    assign bus.mem_to_reg   = ctrl.mem_to_reg;
    assign bus.reg_write    = ctrl.reg_write;
    assign bus.alu_src_a    = ctrl.alu_src_a;
    assign bus.alu_src_b    = ctrl.alu_src_b;
    assign bus.alu_op       = ctrl.alu_op;
    assign bus.pc_source    = ctrl.pc_source;
    assign bus.ext_sign     = ctrl.ext_sign;
    assign bus.illegal_op   = illegal;
    assign bus.instr_count  = cnt_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table walking every instruction class,
// then a hand-written sequence for reset asserted in the middle of a store.
module tb_multicycle_control;
    localparam int CNT_W = 32;

    logic clk;
    logic reset;

    multicycle_control_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word: {pcw,beq,bne,iord,mrd,mwr,irw}_{regdst,m2r,rw}_srca_srcb_aluop_pcsrc_ext_illegal
    localparam logic [19:0] C_IDLE     = 20'b0000000_000_0_00_000_00_1_0;
    localparam logic [19:0] C_FETCH_R  = 20'b1000101_000_0_01_000_00_1_0;
    localparam logic [19:0] C_FETCH_W  = 20'b0000100_000_0_01_000_00_1_0;
    localparam logic [19:0] C_DEC      = 20'b0000000_000_0_11_000_00_1_0;
    localparam logic [19:0] C_DEC_ILL  = 20'b0000000_000_0_11_000_00_1_1;
    localparam logic [19:0] C_MEMADR   = 20'b0000000_000_1_10_000_00_1_0;
    localparam logic [19:0] C_MEMRD    = 20'b0001100_000_0_00_000_00_1_0;
    localparam logic [19:0] C_MEMWB    = 20'b0000000_011_0_00_000_00_1_0;
    localparam logic [19:0] C_MEMWR    = 20'b0001010_000_0_00_000_00_1_0;
    localparam logic [19:0] C_RTYPE    = 20'b0000000_000_1_00_010_00_1_0;
    localparam logic [19:0] C_ALUWB    = 20'b0000000_101_0_00_000_00_1_0;
    localparam logic [19:0] C_BEQ      = 20'b0100000_000_1_00_001_01_1_0;
    localparam logic [19:0] C_BNE      = 20'b0010000_000_1_00_001_01_1_0;
    localparam logic [19:0] C_ADDI     = 20'b0000000_000_1_10_000_00_1_0;
    localparam logic [19:0] C_SLTI     = 20'b0000000_000_1_10_101_00_1_0;
    localparam logic [19:0] C_ANDI     = 20'b0000000_000_1_10_011_00_0_0;
    localparam logic [19:0] C_ORI      = 20'b0000000_000_1_10_100_00_0_0;
    localparam logic [19:0] C_IMMWB_S  = 20'b0000000_001_0_00_000_00_1_0;
    localparam logic [19:0] C_IMMWB_Z  = 20'b0000000_001_0_00_000_00_0_0;
    localparam logic [19:0] C_JUMP     = 20'b1000000_000_0_00_000_10_1_0;

    logic [19:0] act_ctl;
    assign act_ctl = {bus.pc_write, bus.pc_write_beq, bus.pc_write_bne, bus.i_or_d,
                      bus.mem_read, bus.mem_write, bus.ir_write,
                      bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                      bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source,
                      bus.ext_sign, bus.illegal_op};

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [19:0] ctl;
        int          cnt;
    } vec_t;

    vec_t vq[$];
    int   n_checks;
    int   n_pass;

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [19:0] ctl, input int cnt);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b1;

        // IDLE and lw, with mem_ready low in DECODE/MEMADR (ignored) and one MEMRD wait
        add(6'h00, 1, 0,  C_IDLE,    0);
        add(6'h23, 1, 1,  C_FETCH_R, 0);
        add(6'h23, 0, 2,  C_DEC,     0);
        add(6'h23, 0, 3,  C_MEMADR,  0);
        add(6'h23, 0, 4,  C_MEMRD,   0);
        add(6'h23, 1, 4,  C_MEMRD,   0);
        add(6'h23, 1, 5,  C_MEMWB,   0);
        // andi, ori, addi, slti
        add(6'h0C, 1, 1,  C_FETCH_R, 1);
        add(6'h0C, 1, 2,  C_DEC,     1);
        add(6'h0C, 1, 10, C_ANDI,    1);
        add(6'h0C, 1, 11, C_IMMWB_Z, 1);
        add(6'h0D, 1, 1,  C_FETCH_R, 2);
        add(6'h0D, 1, 2,  C_DEC,     2);
        add(6'h0D, 1, 10, C_ORI,     2);
        add(6'h0D, 1, 11, C_IMMWB_Z, 2);
        add(6'h08, 1, 1,  C_FETCH_R, 3);
        add(6'h08, 1, 2,  C_DEC,     3);
        add(6'h08, 1, 10, C_ADDI,    3);
        add(6'h08, 1, 11, C_IMMWB_S, 3);
        add(6'h0A, 1, 1,  C_FETCH_R, 4);
        add(6'h0A, 1, 2,  C_DEC,     4);
        add(6'h0A, 1, 10, C_SLTI,    4);
        add(6'h0A, 1, 11, C_IMMWB_S, 4);
        // beq, bne, R-type, j
        add(6'h04, 1, 1,  C_FETCH_R, 5);
        add(6'h04, 1, 2,  C_DEC,     5);
        add(6'h04, 1, 9,  C_BEQ,     5);
        add(6'h05, 1, 1,  C_FETCH_R, 6);
        add(6'h05, 1, 2,  C_DEC,     6);
        add(6'h05, 1, 9,  C_BNE,     6);
        add(6'h00, 1, 1,  C_FETCH_R, 7);
        add(6'h00, 1, 2,  C_DEC,     7);
        add(6'h00, 1, 7,  C_RTYPE,   7);
        add(6'h00, 1, 8,  C_ALUWB,   7);
        add(6'h02, 1, 1,  C_FETCH_R, 8);
        add(6'h02, 1, 2,  C_DEC,     8);
        add(6'h02, 1, 12, C_JUMP,    8);
        // fetch stall 3 cycles, then an illegal opcode
        add(6'h3F, 0, 1,  C_FETCH_W, 9);
        add(6'h3F, 0, 1,  C_FETCH_W, 9);
        add(6'h3F, 0, 1,  C_FETCH_W, 9);
        add(6'h3F, 1, 1,  C_FETCH_R, 9);
        add(6'h3F, 1, 2,  C_DEC_ILL, 9);
        // sw with one MEMWR wait
        add(6'h2B, 1, 1,  C_FETCH_R, 10);
        add(6'h2B, 1, 2,  C_DEC,     10);
        add(6'h2B, 1, 3,  C_MEMADR,  10);
        add(6'h2B, 0, 6,  C_MEMWR,   10);
        add(6'h2B, 1, 6,  C_MEMWR,   10);
        add(6'h00, 1, 1,  C_FETCH_R, 11);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            bus.opcode    = vq[i].op;
            bus.mem_ready = vq[i].rdy;
            #1;
            chk($sformatf("row%0d state", i), {28'd0, bus.state_dbg}, {28'd0, vq[i].st});
            chk($sformatf("row%0d ctl", i),   {12'd0, act_ctl},       {12'd0, vq[i].ctl});
            chk($sformatf("row%0d count", i), bus.instr_count,         vq[i].cnt);
            @(negedge clk);
        end

        // Reset landing in MEMWR of a store: strobes must drop without waiting for a clock
        reset = 1'b1;
        bus.opcode    = 6'h2B;
        bus.mem_ready = 1'b0;
        #1;
        chk("rst idle state", {28'd0, bus.state_dbg}, 32'd0);
        chk("rst idle count", bus.instr_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("sw memwr state", {28'd0, bus.state_dbg}, 32'd6);
        chk("sw mem_write on", {31'd0, bus.mem_write}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst mem_write", {31'd0, bus.mem_write}, 32'd0);
        chk("midrst ctl", {12'd0, act_ctl}, {12'd0, C_IDLE});
        chk("midrst state", {28'd0, bus.state_dbg}, 32'd0);
        chk("midrst count", bus.instr_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst fetch", {28'd0, bus.state_dbg}, 32'd1);
        chk("post-rst count", bus.instr_count, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences instruction fetch, decode, execute, memory and writeback over shared memory, ALU and register-file resources, driving every datapath select and enable. It also drives the extender mode: sign-extend for arithmetic, address and branch immediates, zero-extend for andi/ori. It sits beside the datapath top, fed by the IR opcode field and a memory-ready handshake.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]; stable from end of FETCH until next FETCH
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_beq  out  1  PC load if ALU zero
pc_write_bne  out  1  PC load if ALU not zero
i_or_d  out  1  memory address: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
reg_dst  out  1  write register: 0=rt, 1=rd
mem_to_reg  out  1  writeback data: 0=ALUOut, 1=MDR
reg_write  out  1  register-file write enable
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=ext imm, 11=ext imm<<2
alu_op  out  3  000 add, 001 sub, 010 use funct, 011 and, 100 or, 101 slt
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
ext_sign  out  1  extender mode: 1=sign, 0=zero
illegal_op  out  1  one-cycle pulse on unsupported opcode
instr_count  out  CNT_W  instructions retired
state_dbg  out  4  current state encoding

Behaviour:
- Async reset: state=IDLE, latched opcode op_q=0, instr_count=0. All outputs are 0 in IDLE except ext_sign=1.
- IDLE -> FETCH unconditionally on the first clock after reset deasserts.
- Outputs are Moore, decoded from state and op_q. Exception: pc_write and ir_write in FETCH are gated by mem_ready. Unlisted outputs are 0 and ext_sign defaults to 1.
- FETCH (1): mem_read, i_or_d=0, src_a=0, src_b=01, add, pc_source=00.
  - ir_write and pc_write only when mem_ready=1.
  - Holds while mem_ready=0; -> DECODE when mem_ready=1.
- DECODE (2): src_a=0, src_b=11, add, ext_sign=1 (branch target precompute). op_q <= opcode. Next state by opcode:
  - 0x23/0x2B -> MEMADR
  - 0x00 -> RTYPE_EX
  - 0x04/0x05 -> BRANCH
  - 0x08/0x0A/0x0C/0x0D -> IMM_EX
  - 0x02 -> JUMP
  - other -> FETCH, with illegal_op pulsed that cycle and instr_count incremented.
- MEMADR (3): src_a=1, src_b=10, add, ext_sign=1. -> MEMRD if op_q=0x23, else MEMWR.
- MEMRD (4): mem_read, i_or_d=1. Holds until mem_ready, then -> MEMWB.
- MEMWB (5): reg_dst=0, mem_to_reg=1, reg_write. -> FETCH.
- MEMWR (6): mem_write, i_or_d=1. Holds until mem_ready, then -> FETCH.
- RTYPE_EX (7): src_a=1, src_b=00, alu_op=010. -> ALUWB.
- ALUWB (8): reg_dst=1, mem_to_reg=0, reg_write. -> FETCH.
- BRANCH (9): src_a=1, src_b=00, sub, pc_source=01. pc_write_beq if op_q=0x04, pc_write_bne if op_q=0x05. -> FETCH.
- IMM_EX (10): src_a=1, src_b=10.
  - addi: add, ext_sign=1.
  - slti: slt, ext_sign=1.
  - andi: and, ext_sign=0.
  - ori: or, ext_sign=0.
  - -> IMMWB.
- IMMWB (11): reg_dst=0, mem_to_reg=0, reg_write. ext_sign held as in IMM_EX. -> FETCH.
- JUMP (12): pc_source=10, pc_write. -> FETCH.
- instr_count increments by 1 on every transition into FETCH from any state except IDLE. It wraps modulo 2^CNT_W.
- Undefined state encodings (0, 13-15 other than IDLE=0 reached by reset) -> FETCH next cycle with no strobes asserted.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR.
- Reset asserted mid-instruction: immediate return to IDLE, all strobes drop in the same cycle, no partial writeback.
- Cycle counts with mem_ready=1 throughout: lw 5, sw 4, R/imm 4, beq/bne 3, j 3.

Decomposition:
- Shared package mips_ctrl_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI), state encodings, ALU_OP_* codes, ALUSRCB_* codes, PCSRC_* codes.
- One sub-module, multicycle_control_outdec: purely combinational mapping {state, op_q, mem_ready} -> control vector. The FSM register, next-state logic and counter stay in the top.

Test Plan:
- lw (opcode 0x23), mem_ready tied 1 -> states 1,2,3,4,5,1. MEMWB has reg_write=1, mem_to_reg=1. instr_count 0->1.
- andi (0x0C) -> IMM_EX shows alu_op=011, alu_src_b=10, ext_sign=0. ori gives ext_sign=0; addi and slti give ext_sign=1.
- beq (0x04) then bne (0x05) -> BRANCH asserts only pc_write_beq, then only pc_write_bne. alu_op=001, pc_source=01. 3 cycles each.
- FETCH with mem_ready low 3 cycles -> state holds, mem_read=1, ir_write=pc_write=0. Then one cycle of ir_write=pc_write=1 when mem_ready rises.
- Opcode 0x3F -> DECODE -> FETCH with illegal_op high exactly 1 cycle and instr_count incremented.
- sw with reset asserted during MEMWR -> mem_write drops the same cycle. state_dbg=0, instr_count=0. FETCH on the first clock after release.
